// File: rtl/reram_layer_controller_if.sv
// Bus bundle for the ReRAM layer controller.
// Groups the pixel input stream, the crossbar pixel-read port, the crossbar
// compute/response handshake and the result output stream.
//   master : the layer controller
//   slave  : the surrounding datapath (pixel source, crossbar, result sink)
interface reram_layer_controller_if #(
  parameter int PIXEL_W = 8,
  parameter int ACC_W   = 16,
  parameter int ADDR_W  = 10
);
  // Pixel input stream
  logic [PIXEL_W-1:0]      in_data;
  logic                    in_valid;
  logic                    in_ready;
  // Crossbar read port into the pixel buffer
  logic [ADDR_W-1:0]       pix_rd_addr;
  logic [PIXEL_W-1:0]      pix_rd_data;
  // Crossbar compute request / partial-sum response
  logic                    xbar_compute;
  logic [15:0]             xbar_neuron_idx;
  logic [7:0]              xbar_tile_idx;
  logic signed [ACC_W-1:0] xbar_result;
  logic                    xbar_valid;
  // Result output stream
  logic                    out_valid;
  logic                    out_ready;
  logic [15:0]             out_idx;
  logic signed [ACC_W-1:0] out_value;

  modport master (
    input  in_data, in_valid, pix_rd_addr, xbar_result, xbar_valid, out_ready,
    output in_ready, pix_rd_data, xbar_compute, xbar_neuron_idx, xbar_tile_idx,
           out_valid, out_idx, out_value
  );

  modport slave (
    output in_data, in_valid, pix_rd_addr, xbar_result, xbar_valid, out_ready,
    input  in_ready, pix_rd_data, xbar_compute, xbar_neuron_idx, xbar_tile_idx,
           out_valid, out_idx, out_value
  );
endinterface

// File: rtl/reram_layer_controller.sv
// ReRAM inference layer sequencer.
// Loads one input vector into a local pixel buffer, then for every output
// neuron issues one crossbar compute per row tile, accumulates the signed
// partial sums, saturates (optionally ReLU-clamps) the total and streams it
// out with backpressure. A crossbar response timeout ends the layer with a
// sticky error flag; abort drops back to idle silently.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start, abort    begin a layer (idle only) / return to idle from anywhere
//   relu_en         ReLU enable, latched when a layer starts
//   busy, done      layer in progress / one-cycle completion or timeout pulse
//   error           sticky timeout flag, cleared by the next accepted start
//   bus             pixel stream, pixel read port, crossbar handshake, results
module reram_layer_controller #(
  parameter int INPUT_SIZE  = 784,
  parameter int OUTPUT_SIZE = 256,
  parameter int TILE_ROWS   = 256,
  parameter int PIXEL_W     = 8,
  parameter int ACC_W       = 16,
  parameter int TIMEOUT     = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  input  logic relu_en,
  output logic busy,
  output logic done,
  output logic error,
  reram_layer_controller_if.master bus
);

  localparam int N_TILES = (INPUT_SIZE + TILE_ROWS - 1) / TILE_ROWS;
  localparam int ADDR_W  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int WAIT_W  = $clog2(TIMEOUT);
  // Eight guard bits keep the running sum exact for up to 256 tiles.
  localparam int SUM_W   = ACC_W + 8;

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(2 ** (ACC_W - 1)));

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]              state_r;
  logic [ADDR_W-1:0]       pix_cnt_r;
  logic [15:0]             neuron_r;
  logic [7:0]              tile_r;
  logic [WAIT_W-1:0]       wait_r;
  logic signed [SUM_W-1:0] acc_r;
  logic signed [SUM_W-1:0] acc_sum_s;
  logic                    relu_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    error_r;
  logic                    compute_r;
  logic                    out_valid_r;
  logic [15:0]             out_idx_r;
  logic signed [ACC_W-1:0] out_value_r;
  logic [PIXEL_W-1:0]      pix_buf_r [INPUT_SIZE];

  logic load_beat_s;
  logic last_pix_s;
  logic last_tile_s;
  logic last_neuron_s;
  logic wait_expired_s;

  // Clamp the wide sum into the output range, then apply ReLU if enabled.
  function automatic logic signed [ACC_W-1:0] sat_relu(
    input logic signed [SUM_W-1:0] value,
    input logic                    relu
  );
    logic signed [SUM_W-1:0] clamped;
    if (value > SAT_MAX) begin
      clamped = SAT_MAX;
    end else if (value < SAT_MIN) begin
      clamped = SAT_MIN;
    end else begin
      clamped = value;
    end
    if (relu && clamped[SUM_W-1]) begin
      clamped = '0;
    end else begin
      clamped = clamped;
    end
    return clamped[ACC_W-1:0];
  endfunction

  assign load_beat_s    = bus.in_valid && (state_r == S_LOAD);
  assign last_pix_s     = (pix_cnt_r == ADDR_W'(INPUT_SIZE - 1));
  assign last_tile_s    = (tile_r == 8'(N_TILES - 1));
  assign last_neuron_s  = (neuron_r == 16'(OUTPUT_SIZE - 1));
  // Compared one below TIMEOUT: this is the cycle the count would reach it.
  assign wait_expired_s = (wait_r == WAIT_W'(TIMEOUT - 1));
  assign acc_sum_s      = acc_r + $signed({{8{bus.xbar_result[ACC_W-1]}}, bus.xbar_result});

  assign bus.in_ready        = (state_r == S_LOAD);
  assign bus.pix_rd_data     = pix_buf_r[bus.pix_rd_addr];
  assign bus.xbar_compute    = compute_r;
  assign bus.xbar_neuron_idx = neuron_r;
  assign bus.xbar_tile_idx   = tile_r;
  assign bus.out_valid       = out_valid_r;
  assign bus.out_idx         = out_idx_r;
  assign bus.out_value       = out_value_r;
  assign busy                = busy_r;
  assign done                = done_r;
  assign error               = error_r;

  // Pixel buffer write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (load_beat_s) begin
      pix_buf_r[pix_cnt_r] <= bus.in_data;
    end
  end

  // Layer sequencer: state, counters, accumulator and all registered outputs.
  // Pulsed outputs (compute, done) are set on entry to the state they mark.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      pix_cnt_r   <= '0;
      neuron_r    <= 16'd0;
      tile_r      <= 8'd0;
      wait_r      <= '0;
      acc_r       <= '0;
      relu_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      compute_r   <= 1'b0;
      out_valid_r <= 1'b0;
      out_idx_r   <= 16'd0;
      out_value_r <= '0;
    end else if (abort && (state_r != S_IDLE)) begin
      state_r     <= S_IDLE;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      compute_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      compute_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            state_r   <= S_LOAD;
            busy_r    <= 1'b1;
            error_r   <= 1'b0;
            relu_r    <= relu_en;
            pix_cnt_r <= '0;
            neuron_r  <= 16'd0;
            tile_r    <= 8'd0;
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            if (last_pix_s) begin
              state_r   <= S_ISSUE;
              compute_r <= 1'b1;
            end else begin
              pix_cnt_r <= pix_cnt_r + ADDR_W'(1);
            end
          end
        end
        S_ISSUE: begin
          wait_r  <= '0;
          state_r <= S_WAIT;
          if (tile_r == 8'd0) begin
            acc_r <= '0;
          end
        end
        S_WAIT: begin
          // A response in the expiry cycle still counts.
          if (bus.xbar_valid) begin
            acc_r <= acc_sum_s;
            if (last_tile_s) begin
              state_r     <= S_EMIT;
              out_valid_r <= 1'b1;
              out_idx_r   <= neuron_r;
              out_value_r <= sat_relu(acc_sum_s, relu_r);
            end else begin
              tile_r    <= tile_r + 8'd1;
              state_r   <= S_ISSUE;
              compute_r <= 1'b1;
            end
          end else if (wait_expired_s) begin
            state_r <= S_IDLE;
            error_r <= 1'b1;
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
          end else begin
            wait_r <= wait_r + WAIT_W'(1);
          end
        end
        S_EMIT: begin
          // out_valid is always high here, so out_ready alone completes the beat.
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (last_neuron_s) begin
              state_r <= S_DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              neuron_r  <= neuron_r + 16'd1;
              tile_r    <= 8'd0;
              state_r   <= S_ISSUE;
              compute_r <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reram_layer_controller.sv
// Randomized scoreboard bench for reram_layer_controller.
// Configuration: 8 pixels, 4 rows per tile (2 tiles), 3 neurons, timeout 16.
module tb_reram_layer_controller;

  localparam int IN_SZ  = 8;
  localparam int OUT_SZ = 3;
  localparam int TROWS  = 4;
  localparam int NT     = 2;
  localparam int TMO    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic relu_en = 1'b0;
  logic busy, done, error;

  reram_layer_controller_if #(.PIXEL_W(8), .ACC_W(16), .ADDR_W(3)) bus ();

  reram_layer_controller #(
    .INPUT_SIZE(IN_SZ), .OUTPUT_SIZE(OUT_SZ), .TILE_ROWS(TROWS),
    .PIXEL_W(8), .ACC_W(16), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .relu_en(relu_en),
    .busy(busy), .done(done), .error(error), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {int idx; int val;} exp_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   part [OUT_SZ][NT];
  logic [7:0] pix [IN_SZ];
  int   resp_mode = 0;   // 0 random delay, 1 never respond, 2 respond in last allowed cycle
  int   issue_cnt = 0;
  int   cmp_cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  bit   hold_ready = 1'b0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream sink: random backpressure unless held low.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Crossbar model: checks issue order (neuron-major, tile-minor) and answers.
  initial begin
    int n, t, d;
    bus.xbar_valid  = 1'b0;
    bus.xbar_result = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.xbar_compute) begin
        n = issue_cnt / NT;
        t = issue_cnt % NT;
        issue_cnt++;
        cmp_cyc = cyc;
        chk("xbar_neuron_idx", bus.xbar_neuron_idx, n);
        chk("xbar_tile_idx", bus.xbar_tile_idx, t);
        if (resp_mode != 1 && n < OUT_SZ) begin
          d = (resp_mode == 2) ? TMO - 1 : $urandom_range(0, 3);
          @(posedge clk);
          repeat (d) @(posedge clk);
          #1;
          bus.xbar_valid  = 1'b1;
          bus.xbar_result = 16'(part[n][t]);
          @(posedge clk);
          #1;
          bus.xbar_valid = 1'b0;
        end
      end
    end
  end

  // Output monitor: scoreboard pops, hold stability, done pulse shape.
  initial begin
    bit pv, pr, pd, pb, pdn;
    logic [15:0] pi;
    logic signed [15:0] pval;
    exp_t e;
    pv = 1'b0; pr = 1'b0; pd = 1'b1; pb = 1'b0; pdn = 1'b0; pi = '0; pval = '0;
    forever begin
      @(negedge clk);
      if (pv && !pr && !pd) begin
        chk("out_valid_held", bus.out_valid, 1);
        chk("out_idx_stable", bus.out_idx, pi);
        chk("out_value_stable", bus.out_value, pval);
      end
      if (bus.out_valid === 1'b1) begin
        chk("no_compute_in_emit", bus.xbar_compute, 0);
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_idx", bus.out_idx, e.idx);
            chk("out_value", bus.out_value, e.val);
          end
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_low_with_done", busy, 0);
        chk("busy_before_done", pb, 1);
        chk("done_single_cycle", pdn, 0);
      end
      pv = (bus.out_valid === 1'b1);
      pr = bus.out_ready;
      pd = !rst_n || abort;
      pb = (busy === 1'b1);
      pdn = (done === 1'b1);
      pi = bus.out_idx;
      pval = bus.out_value;
    end
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: sum tile partials, clamp to 16-bit signed, optional ReLU.
  task automatic push_expected(input bit relu);
    int s;
    for (int n = 0; n < OUT_SZ; n++) begin
      s = 0;
      for (int t = 0; t < NT; t++) s += part[n][t];
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      if (relu && s < 0) s = 0;
      exp_q.push_back('{n, s});
    end
  endtask

  task automatic do_start(input bit relu);
    relu_en = relu;
    start = 1'b1;
    tick;
    start = 1'b0;
    relu_en = 1'($urandom_range(0, 1));
    chk("busy_after_start", busy, 1);
    chk("error_cleared_by_start", error, 0);
    chk("in_ready_in_load", bus.in_ready, 1);
  endtask

  task automatic load_pixels(input int count);
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data = 8'($urandom);
        tick;
      end
      pix[i] = 8'($urandom);
      bus.in_data = pix[i];
      bus.in_valid = 1'b1;
      tick;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done;
    int d0, n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      tick;
      n++;
    end
    chk("done_within_budget", (done_cnt != d0), 1);
  endtask

  task automatic run_layer(input bit relu, input int mode, input bit poke, input bit stall, input bit exp_err);
    int d0, n;
    resp_mode = mode;
    issue_cnt = 0;
    if (!exp_err) push_expected(relu);
    d0 = done_cnt;
    if (stall) hold_ready = 1'b1;
    do_start(relu);
    load_pixels(IN_SZ);
    if (poke) begin
      repeat (3) tick;
      start = 1'b1;
      tick;
      start = 1'b0;
    end
    if (stall) begin
      n = 0;
      while (bus.out_valid !== 1'b1 && n < 500) begin
        tick;
        n++;
      end
      chk("stall_reached_emit", bus.out_valid, 1);
      repeat (10) tick;
      hold_ready = 1'b0;
    end
    wait_done;
    repeat (2) tick;
    chk("done_count", done_cnt - d0, 1);
    chk("error_flag", error, exp_err);
    chk("busy_idle", busy, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    if (exp_err) chk("timeout_issue_count", issue_cnt, 1);
    else chk("issue_count", issue_cnt, OUT_SZ * NT);
    exp_q.delete();
    for (int i = 0; i < IN_SZ; i++) begin
      bus.pix_rd_addr = 3'(i);
      #1;
      chk("pix_readback", bus.pix_rd_data, pix[i]);
    end
  endtask

  task automatic set_parts(input int a, input int b);
    for (int n = 0; n < OUT_SZ; n++) begin
      part[n][0] = a;
      part[n][1] = b;
    end
  endtask

  task automatic rand_parts;
    for (int n = 0; n < OUT_SZ; n++)
      for (int t = 0; t < NT; t++) part[n][t] = $urandom_range(0, 40000) - 20000;
  endtask

  initial begin
    int d0, n;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.pix_rd_addr = '0;
    repeat (3) tick;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_xbar_compute", bus.xbar_compute, 0);
    chk("rst_neuron_idx", bus.xbar_neuron_idx, 0);
    chk("rst_tile_idx", bus.xbar_tile_idx, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_idx", bus.out_idx, 0);
    chk("rst_out_value", bus.out_value, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    rst_n = 1'b1;
    tick;

    // 100 + (-30) per neuron, first output stalled for 10 cycles
    set_parts(100, -30);
    run_layer(1'b0, 0, 1'b0, 1'b1, 1'b0);
    // Saturation both ways, and ReLU on the negative saturation
    set_parts(30000, 30000);
    run_layer(1'b0, 0, 1'b0, 1'b0, 1'b0);
    set_parts(-30000, -30000);
    run_layer(1'b0, 0, 1'b0, 1'b0, 1'b0);
    run_layer(1'b1, 0, 1'b0, 1'b0, 1'b0);
    // Random layers; one with a stray start while busy
    for (int k = 0; k < 4; k++) begin
      rand_parts();
      run_layer(1'($urandom_range(0, 1)), 0, (k == 1), 1'b0, 1'b0);
    end

    // Timeout: no response at all
    run_layer(1'b0, 1, 1'b0, 1'b0, 1'b1);
    chk("timeout_cycles", done_cyc - cmp_cyc, TMO + 1);
    // Response in the final allowed cycle: no error
    rand_parts();
    run_layer(1'b0, 2, 1'b0, 1'b0, 1'b0);

    // Abort during LOAD after 3 pixels
    d0 = done_cnt;
    resp_mode = 0;
    issue_cnt = 0;
    do_start(1'b0);
    load_pixels(3);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_load_busy", busy, 0);
    chk("abort_load_idle", bus.in_ready, 0);
    chk("abort_load_out_valid", bus.out_valid, 0);
    repeat (5) tick;
    chk("abort_load_no_done", done_cnt - d0, 0);

    // Abort during WAIT
    resp_mode = 1;
    issue_cnt = 0;
    do_start(1'b0);
    load_pixels(IN_SZ);
    n = 0;
    while (issue_cnt == 0 && n < 100) begin
      tick;
      n++;
    end
    chk("abort_wait_issued", issue_cnt, 1);
    repeat (4) tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_wait_busy", busy, 0);
    chk("abort_wait_compute", bus.xbar_compute, 0);
    chk("abort_wait_out_valid", bus.out_valid, 0);
    chk("abort_wait_error", error, 0);
    repeat (TMO + 4) tick;
    chk("abort_wait_no_done", done_cnt - d0, 0);
    chk("abort_wait_no_error", error, 0);

    // Full run after aborts
    rand_parts();
    run_layer(1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Reset while a result is waiting in EMIT
    hold_ready = 1'b1;
    resp_mode = 0;
    issue_cnt = 0;
    do_start(1'b0);
    load_pixels(IN_SZ);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 500) begin
      tick;
      n++;
    end
    chk("reset_test_in_emit", bus.out_valid, 1);
    rst_n = 1'b0;
    tick;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_error", error, 0);
    chk("mid_rst_compute", bus.xbar_compute, 0);
    chk("mid_rst_neuron_idx", bus.xbar_neuron_idx, 0);
    chk("mid_rst_tile_idx", bus.xbar_tile_idx, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_idx", bus.out_idx, 0);
    chk("mid_rst_out_value", bus.out_value, 0);
    rst_n = 1'b1;
    hold_ready = 1'b0;
    exp_q.delete();
    tick;

    // Operational again after reset
    rand_parts();
    run_layer(1'b1, 0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
